// File: rtl/handshake_arb_pkg.sv
// Shared types and helpers for the handshake bus arbiter: FSM state encoding,
// default parameter values and a one-hot grant encoder.
package handshake_arb_pkg;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_GNT_TIMEOUT = 16;

    // Upper bound on requesters; sizes the one-hot helper below.
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_XFER,
        ARB_DROP
    } arb_state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/handshake_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first asserted request searching upward
// from the requester after the previous owner, wrapping modulo N_REQ.
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every variable gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        cand     = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((int'(last_i) + off) % N_REQ);
            if (!found && req_i[cand]) begin
                winner_o = cand;
                found    = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/handshake_bus_arbiter.sv
// Round-robin arbiter sharing one 4-phase ready/accepted channel among N_REQ
// producers; one transfer per grant, idle grants revoked after GNT_TIMEOUT cycles.
module handshake_bus_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    output logic [N_REQ-1:0]        gnt,
    input  logic [N_REQ-1:0]        ready_in,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        accepted_out,
    output logic                    ready_out,
    output logic [DATA_W-1:0]       data_out,
    input  logic                    accepted_in,
    output logic                    busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(GNT_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);

    arb_state_t       state_q,  state_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic [IDX_W-1:0] last_q,   last_d;
    logic [TMR_W-1:0] timer_q,  timer_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            winner_q <= '0;
            last_q   <= IDX_W'(N_REQ - 1);
            timer_q  <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            gnt_q    <= gnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        timer_d  = timer_q;
        gnt_d    = gnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_GRANT;
                    winner_d = pick_idx;
                    timer_d  = '0;
                    gnt_d    = N_REQ'(onehot(MAX_IDX_W'(pick_idx)));
                end
            end
            ARB_GRANT: begin
                // A ready seen on the last timeout cycle still wins over revocation.
                if (ready_in[winner_q]) begin
                    state_d = ARB_XFER;
                end else if (!req[winner_q] || timer_q == TMR_LAST) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    last_d  = winner_q;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ARB_XFER: begin
                if (accepted_in) begin
                    state_d = ARB_DROP;
                end
            end
            ARB_DROP: begin
                if (!ready_in[winner_q] && !accepted_in) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    last_d  = winner_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Channel is routed only while the owner is mid-handshake; everything else reads as idle.
    always_comb begin
        ready_out    = 1'b0;
        data_out     = '0;
        accepted_out = '0;
        if (state_q == ARB_XFER || state_q == ARB_DROP) begin
            ready_out              = ready_in[winner_q];
            data_out               = data_in[winner_q*DATA_W +: DATA_W];
            accepted_out[winner_q] = accepted_in;
        end
    end

    assign busy = (state_q != ARB_IDLE);
    assign gnt  = gnt_q;

endmodule

// File: tb/tb_handshake_bus_arbiter.sv
// Directed bench for handshake_bus_arbiter: a transaction-level reference model
// is compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_handshake_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   ready_in = '0;
    logic [N*W-1:0] data_in = '0;
    logic           accepted_in = 1'b0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   accepted_out;
    logic           ready_out;
    logic [W-1:0]   data_out;
    logic           busy;

    always #5 clk = ~clk;

    handshake_bus_arbiter #(
        .N_REQ       (N),
        .DATA_W      (W),
        .GNT_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .ready_in     (ready_in),
        .data_in      (data_in),
        .accepted_out (accepted_out),
        .ready_out    (ready_out),
        .data_out     (data_out),
        .accepted_in  (accepted_in),
        .busy         (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the bus, whether their ready has been seen,
    // whether the consumer has accepted, and how long the owner has idled.
    int m_owner = -1;
    bit m_moved = 1'b0;
    bit m_acc   = 1'b0;
    int m_wait  = 0;
    int m_last  = N - 1;

    function automatic int rr_pick(input int last_v, input logic [N-1:0] r);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (last_v + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= -1;
            m_moved <= 1'b0;
            m_acc   <= 1'b0;
            m_wait  <= 0;
            m_last  <= N - 1;
        end else if (m_owner < 0) begin
            if (req != '0) begin
                m_owner <= rr_pick(m_last, req);
                m_moved <= 1'b0;
                m_acc   <= 1'b0;
                m_wait  <= 0;
            end
        end else if (!m_moved) begin
            if (ready_in[m_owner]) begin
                m_moved <= 1'b1;
            end else if (!req[m_owner] || m_wait + 1 >= TO) begin
                m_last  <= m_owner;
                m_owner <= -1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (!m_acc) begin
            if (accepted_in) m_acc <= 1'b1;
        end else if (!ready_in[m_owner] && !accepted_in) begin
            m_last  <= m_owner;
            m_owner <= -1;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_acc;
        logic         e_rdy;
        logic [W-1:0] e_data;
        if (cmp_en) begin
            e_gnt  = '0;
            e_acc  = '0;
            e_rdy  = 1'b0;
            e_data = '0;
            if (m_owner >= 0) begin
                e_gnt = N'(1) << m_owner;
                if (m_moved) begin
                    e_rdy  = ready_in[m_owner];
                    e_data = data_in[m_owner*W +: W];
                    e_acc  = N'(accepted_in) << m_owner;
                end
            end
            check("cyc gnt",          64'(gnt),          64'(e_gnt));
            check("cyc busy",         64'(busy),         64'(m_owner >= 0));
            check("cyc ready_out",    64'(ready_out),    64'(e_rdy));
            check("cyc data_out",     data_out,          e_data);
            check("cyc accepted_out", 64'(accepted_out), 64'(e_acc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string name, output int idx);
        idx = -1;
        for (int i = 0; i < 40; i++) begin
            if (gnt != '0) break;
            step();
        end
        check({name, " grant arrives"}, 64'(gnt != '0), 64'(1));
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) idx = i;
        end
    endtask

    task automatic xfer(input int idx, input logic [W-1:0] data);
        ready_in[idx]        = 1'b1;
        data_in[idx*W +: W]  = data;
        step();
        check("xfer data_out", data_out, data);
        accepted_in = 1'b1;
        step();
        ready_in[idx] = 1'b0;
        accepted_in   = 1'b0;
        step();
        check("xfer gap gnt", 64'(gnt), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int order_exp[5] = '{0, 1, 2, 3, 0};
    int idx;

    initial begin
        step();
        cmp_en = 1'b1;
        step();
        rst = 1'b0;
        check("reset gnt",          64'(gnt),          64'(0));
        check("reset busy",         64'(busy),         64'(0));
        check("reset ready_out",    64'(ready_out),    64'(0));
        check("reset data_out",     data_out,          64'(0));
        check("reset accepted_out", 64'(accepted_out), 64'(0));

        // 1: single transfer from requester 0
        req = 4'b0001;
        check("t1 gnt before edge", 64'(gnt), 64'(0));
        step();
        check("t1 gnt latency", 64'(gnt), 64'(4'b0001));
        step();
        step();
        ready_in[0]    = 1'b1;
        data_in[0 +: W] = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("t1 no ready_out in grant", 64'(ready_out), 64'(0));
        step();
        check("t1 ready_out", 64'(ready_out), 64'(1));
        check("t1 data_out",  data_out, 64'hDEAD_BEEF_0123_4567);
        step();
        step();
        step();
        accepted_in = 1'b1;
        #1;
        check("t1 accepted_out follows", 64'(accepted_out), 64'(4'b0001));
        step();
        ready_in[0] = 1'b0;
        req         = 4'b0000;
        #1;
        check("t1 drop accepted_out", 64'(accepted_out), 64'(4'b0001));
        step();
        check("t1 gnt held in drop", 64'(gnt), 64'(4'b0001));
        accepted_in = 1'b0;
        step();
        check("t1 gnt released", 64'(gnt),  64'(0));
        check("t1 busy released", 64'(busy), 64'(0));

        // 2: all requesting, rotation 0,1,2,3,0 from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("t2", idx);
            check($sformatf("t2 order %0d", k), 64'(idx), 64'(order_exp[k]));
            if (idx >= 0) xfer(idx, {32'hC0DE_0000, 32'(k)});
        end
        req = 4'b0000;

        // 3: requester 2 never raises ready; revoked after TO cycles, then 3 wins
        req = 4'b1100;
        step();
        check("t3 gnt to 2", 64'(gnt), 64'(4'b0100));
        for (int i = 0; i < TO - 1; i++) begin
            step();
            check("t3 gnt held", 64'(gnt), 64'(4'b0100));
        end
        step();
        check("t3 gnt revoked", 64'(gnt),  64'(0));
        check("t3 busy low",    64'(busy), 64'(0));
        check("t3 model last",  64'(m_last), 64'(2));
        step();
        check("t3 next winner 3", 64'(gnt), 64'(4'b1000));
        req = 4'b0000;
        step();
        check("t3 released", 64'(gnt), 64'(0));

        // 4: requester 1 drops req while granted
        req = 4'b0010;
        step();
        check("t4 gnt to 1", 64'(gnt), 64'(4'b0010));
        step();
        req = 4'b0000;
        step();
        check("t4 gnt revoked", 64'(gnt),       64'(0));
        check("t4 busy low",    64'(busy),      64'(0));
        check("t4 no ready",    64'(ready_out), 64'(0));

        // 5: reset mid-transfer
        req = 4'b0001;
        step();
        check("t5 gnt to 0", 64'(gnt), 64'(4'b0001));
        ready_in[0]     = 1'b1;
        data_in[0 +: W] = 64'h1234_5678_9ABC_DEF0;
        step();
        check("t5 ready_out in xfer", 64'(ready_out), 64'(1));
        rst = 1'b1;
        step();
        check("t5 gnt after rst",          64'(gnt),          64'(0));
        check("t5 ready_out after rst",    64'(ready_out),    64'(0));
        check("t5 accepted_out after rst", 64'(accepted_out), 64'(0));
        check("t5 busy after rst",         64'(busy),         64'(0));
        check("t5 model last",             64'(m_last),       64'(3));
        rst         = 1'b0;
        ready_in[0] = 1'b0;
        req         = 4'b1001;
        step();
        check("t5 requester 0 first", 64'(gnt), 64'(4'b0001));
        req = 4'b0000;
        step();
        check("t5 released", 64'(gnt), 64'(0));

        // 6: non-granted requester 3 drives ready/data; must be invisible
        req             = 4'b0001;
        ready_in[3]     = 1'b1;
        data_in[3*W +: W] = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        check("t6 gnt to 0",         64'(gnt),       64'(4'b0001));
        check("t6 ready_out idle",   64'(ready_out), 64'(0));
        check("t6 data_out idle",    data_out,       64'(0));
        ready_in[0]     = 1'b1;
        data_in[0 +: W] = 64'h0F0F_1E1E_2D2D_3C3C;
        step();
        check("t6 data_out owner",  data_out,       64'h0F0F_1E1E_2D2D_3C3C);
        check("t6 ready_out owner", 64'(ready_out), 64'(1));
        accepted_in = 1'b1;
        #1;
        check("t6 accepted_out owner only", 64'(accepted_out), 64'(4'b0001));
        step();
        ready_in[0] = 1'b0;
        req         = 4'b0000;
        step();
        check("t6 drop accepted_out", 64'(accepted_out), 64'(4'b0001));
        check("t6 drop ready_out",    64'(ready_out),    64'(0));
        accepted_in = 1'b0;
        step();
        check("t6 released", 64'(gnt), 64'(0));
        accepted_in = 1'b1;
        #1;
        check("t6 accepted ignored in idle", 64'(accepted_out), 64'(0));
        step();
        accepted_in = 1'b0;
        ready_in    = '0;
        step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
